// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU types and helpers: default multiplier geometry,
//                the multiplier-share FSM state encoding and an id-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned WIDTH_DEF       = 8;
    localparam int unsigned MUL_LATENCY_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Width of an index able to name n items; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches upward from the
//                entry after ptr, wrapping, and returns the first request.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned ID_W = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    logic [ID_W-1:0] idx;

    // First active request after ptr, wrapping modulo N_REQ.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int off = 1; off <= int'(N_REQ); off++) begin
            idx = ID_W'((int'(ptr) + off) % int'(N_REQ));
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant_id   = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_ctrl
//  Description : Shares one fixed-latency multiplier among N_REQ requesters.
//                Round-robin grant in IDLE, operands held for MUL_LATENCY
//                cycles in RUN, tagged product held in RESP until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
    localparam int unsigned ID_W       = id_width(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    mul_a_q, mul_a_d;
    logic [WIDTH-1:0]    mul_b_q, mul_b_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]     resp_id_q, resp_id_d;
    logic [2*WIDTH-1:0]  resp_product_q, resp_product_d;

    logic [WIDTH-1:0]    a_arr [N_REQ];
    logic [WIDTH-1:0]    b_arr [N_REQ];
    logic [N_REQ-1:0]    gnt_onehot;
    logic [ID_W-1:0]     gnt_id;
    logic                gnt_any;

    genvar gi;
    generate
        for (gi = 0; gi < int'(N_REQ); gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ     (N_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (gnt_onehot),
        .grant_id  (gnt_id),
        .grant_any (gnt_any)
    );

    // Next-state, grant and capture logic; everything holds unless a state acts.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        resp_valid_d   = resp_valid_q;
        resp_id_d      = resp_id_q;
        resp_product_d = resp_product_q;
        req_ready      = '0;
        case (state_q)
            ST_IDLE: begin
                // The grant only targets a valid requester, so ready implies handshake.
                if (gnt_any) begin
                    req_ready = gnt_onehot;
                    mul_a_d   = a_arr[gnt_id];
                    mul_b_d   = b_arr[gnt_id];
                    resp_id_d = gnt_id;
                    rr_ptr_d  = gnt_id;
                    cnt_d     = CNT_W'(MUL_LATENCY);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    resp_product_d = mul_product;
                    resp_valid_d   = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= ID_W'(N_REQ - 1);
            cnt_q          <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_product_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_product_q <= resp_product_d;
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_product = resp_product_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_share_ctrl
//  Description : Scoreboard bench for mul_share_ctrl with a latency-honest
//                multiplier stand-in (garbage until A/B have been stable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_ctrl;

    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [2*W-1:0] resp_product;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_product;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int grant_cnt = 0;
    int last_grant_cyc = -1;
    int stall_req  = 0;
    int stall_left = 0;

    int          exp_grant_q[$];
    logic [17:0] exp_resp_q[$];

    mul_share_ctrl #(
        .N_REQ        (N),
        .WIDTH        (W),
        .MUL_LATENCY  (L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: product only valid once A/B held for L cycles.
    logic [W-1:0]          pa = '0;
    logic [W-1:0]          pb = '0;
    int                    stable = 0;
    logic signed [2*W-1:0] prod_full;
    assign prod_full   = $signed(mul_a) * $signed(mul_b);
    assign mul_product = (mul_a == pa && mul_b == pb && stable >= L - 1) ? prod_full : 16'hDEAD;
    always @(posedge clk) begin
        if (mul_a != pa || mul_b != pb) stable <= 1;
        else if (stable < 1000)         stable <= stable + 1;
        pa <= mul_a;
        pb <= mul_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant order/interval, response latency, stability and payload.
    initial begin : monitor
        logic       prev_valid;
        logic [1:0] held_id;
        logic [15:0] held_p;
        logic [N-1:0] hs;
        logic [17:0] er;
        int eg;
        prev_valid = 1'b0;
        held_id    = '0;
        held_p     = '0;
        resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
                resp_ready = 1'b1;
                continue;
            end
            chk("ready_only_in_idle", {31'd0, busy && (req_ready != '0)}, 32'd0);
            chk("ready_onehot", {31'd0, $countones(req_ready) <= 1}, 32'd1);
            hs = req_valid & req_ready;
            if (hs != '0) begin
                if (exp_grant_q.size() == 0) begin
                    chk("unexpected_grant", {28'd0, hs}, 32'd0);
                end else begin
                    eg = exp_grant_q.pop_front();
                    chk("grant_id", {28'd0, hs}, 32'(1 << eg));
                end
                if (last_grant_cyc >= 0)
                    chk("grant_interval", {31'd0, (cyc - last_grant_cyc) >= L + 2}, 32'd1);
                last_grant_cyc = cyc;
                grant_cnt++;
            end
            if (resp_valid) begin
                if (!prev_valid) begin
                    chk("resp_latency", 32'(cyc), 32'(last_grant_cyc + L + 1));
                    stall_left = stall_req;
                    stall_req  = 0;
                end else begin
                    chk("resp_stable", {14'd0, resp_id, resp_product}, {14'd0, held_id, held_p});
                end
                held_id = resp_id;
                held_p  = resp_product;
                if (stall_left > 0) begin
                    resp_ready = 1'b0;
                    stall_left--;
                end else begin
                    resp_ready = 1'b1;
                    if (exp_resp_q.size() == 0) begin
                        chk("unexpected_resp", {14'd0, resp_id, resp_product}, 32'd0);
                    end else begin
                        er = exp_resp_q.pop_front();
                        chk("resp_id", {30'd0, resp_id}, {30'd0, er[17:16]});
                        chk("resp_product", {16'd0, resp_product}, {16'd0, er[15:0]});
                    end
                end
            end else begin
                resp_ready = 1'b1;
            end
            prev_valid = resp_valid;
        end
    end

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    task automatic expect_op(input int id, input logic [15:0] p);
        exp_grant_q.push_back(id);
        exp_resp_q.push_back({2'(id), p});
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset          = 1'b0;
        last_grant_cyc = -1;
    endtask

    // Hold mask asserted until n more grants occurred, then drop all valids.
    task automatic run_grants(input logic [N-1:0] mask, input int n);
        int target;
        int t;
        target    = grant_cnt + n;
        t         = 0;
        req_valid = mask;
        while (grant_cnt < target && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        req_valid = '0;
        if (grant_cnt < target) chk("grant_timeout", 32'(grant_cnt), 32'(target));
    endtask

    task automatic wait_idle;
        int t;
        t = 0;
        while ((busy || resp_valid || exp_resp_q.size() != 0 || exp_grant_q.size() != 0) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) chk("idle_timeout", 32'(exp_resp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset          = 1'b0;
        last_grant_cyc = -1;

        chk("rst_resp_valid",   {31'd0, resp_valid}, 32'd0);
        chk("rst_busy",         {31'd0, busy}, 32'd0);
        chk("rst_mul_a",        {24'd0, mul_a}, 32'd0);
        chk("rst_mul_b",        {24'd0, mul_b}, 32'd0);
        chk("rst_resp_id",      {30'd0, resp_id}, 32'd0);
        chk("rst_resp_product", {16'd0, resp_product}, 32'd0);
        chk("rst_req_ready",    {28'd0, req_ready}, 32'd0);

        // req0: 8*9 = 72, then operands scrambled during RUN
        set_ops(0, 8'd8, 8'd9);
        expect_op(0, 16'd72);
        run_grants(4'b0001, 1);
        chk("mul_a_captured", {24'd0, mul_a}, 32'd8);
        chk("mul_b_captured", {24'd0, mul_b}, 32'd9);
        set_ops(0, 8'hA5, 8'h5A);
        repeat (3) @(posedge clk);
        #1;
        chk("mul_a_held", {24'd0, mul_a}, 32'd8);
        chk("mul_b_held", {24'd0, mul_b}, 32'd9);
        wait_idle();

        // req1: 10*11 = 110 with consumer stalling 3 cycles
        set_ops(1, 8'd10, 8'd11);
        stall_req = 3;
        expect_op(1, 16'd110);
        run_grants(4'b0010, 1);
        wait_idle();

        // req2: -3*5 = -15
        set_ops(2, 8'hFD, 8'd5);
        expect_op(2, 16'hFFF1);
        run_grants(4'b0100, 1);
        chk("mul_a_signed", {24'd0, mul_a}, 32'h0000_00FD);
        wait_idle();

        // rr_ptr=2, req1 and req3 valid: grant 3 then 1 (wrap)
        set_ops(1, 8'h80, 8'h7F);
        set_ops(3, 8'h80, 8'h80);
        expect_op(3, 16'h4000);
        expect_op(1, 16'hC080);
        run_grants(4'b1010, 2);
        wait_idle();

        // all four from reset: order 0,1,2,3,0
        do_reset();
        set_ops(0, 8'd2, 8'd3);
        set_ops(1, 8'hFF, 8'hFF);
        set_ops(2, 8'h7F, 8'h7F);
        set_ops(3, 8'hF9, 8'd6);
        expect_op(0, 16'd6);
        expect_op(1, 16'd1);
        expect_op(2, 16'h3F01);
        expect_op(3, 16'hFFD6);
        expect_op(0, 16'd6);
        run_grants(4'b1111, 5);
        wait_idle();

        // reset in RUN cycle 4: product discarded, next grant to req0
        do_reset();
        set_ops(1, 8'd3, 8'd3);
        exp_grant_q.push_back(1);
        run_grants(4'b0010, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("run_busy", {31'd0, busy}, 32'd1);
        do_reset();
        chk("abort_busy",       {31'd0, busy}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_mul_a",      {24'd0, mul_a}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        set_ops(0, 8'd6, 8'hF9);
        expect_op(0, 16'hFFD6);
        run_grants(4'b0011, 1);
        wait_idle();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Round-robin scheduler that shares one booth_multiplier instance among N_REQ requesters in the ALU. It accepts signed operand pairs over per-requester valid/ready handshakes and drives the multiplier's A/B inputs. It holds the operands stable for the multiplier's fixed latency, captures Output, and returns the product tagged with the requester id. Only one multiplication is in flight at a time.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand width; product is 2*WIDTH
MUL_LATENCY, 8, clk cycles the multiplier needs from stable A/B to valid Output (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester accept; at most one bit high
req_a  in  N_REQ*WIDTH  packed signed multiplicands; requester i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  packed signed multipliers, same packing
resp_valid  out  1  product available
resp_ready  in  1  consumer accepts product
resp_id  out  clog2(N_REQ)  requester index of the product
resp_product  out  2*WIDTH  signed product
mul_a  out  WIDTH  to booth_multiplier A
mul_b  out  WIDTH  to booth_multiplier B
mul_product  in  2*WIDTH  from booth_multiplier Output
busy  out  1  high in RUN or RESP

Behaviour:
- Reset, synchronous, checked every edge and overriding all else:
  - state=IDLE, rr_ptr=N_REQ-1 so requester 0 has first priority.
  - mul_a=0, mul_b=0, resp_valid=0, resp_id=0, resp_product=0, busy=0, counter=0.
- States: IDLE, RUN, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching (rr_ptr+1) mod N_REQ upward with wrap.
  - req_ready[g]=1, combinational, only in IDLE; all req_ready=0 in RUN and RESP.
  - Handshake at edge T (req_valid[g] & req_ready[g]):
    - mul_a<=req_a[g], mul_b<=req_b[g], resp_id<=g, rr_ptr<=g, counter<=MUL_LATENCY, state<=RUN.
  - No valid requests: remain in IDLE, no register changes.
- RUN:
  - mul_a and mul_b held constant. Counter decrements each cycle.
  - When counter==1: resp_product<=mul_product, resp_valid<=1, state<=RESP.
  - RUN spans cycles T+1..T+MUL_LATENCY; resp_valid is first high in cycle T+MUL_LATENCY+1.
- RESP:
  - resp_valid, resp_id and resp_product held stable until resp_valid & resp_ready.
  - On that handshake: resp_valid<=0, state<=IDLE.
  - No new grant in the same cycle as the response handshake. Minimum issue interval per product is MUL_LATENCY+2 cycles.
- Arithmetic:
  - Two's-complement signed; the product is passed through untouched.
  - WIDTH=8 range is -128*-128=+16384 down to -128*127=-16256; no truncation.
- Fairness: a continuously asserting requester is served at least once every N_REQ grants.
- req_valid deasserting while not granted is legal; no state is kept for it.
- Operand changes on req_a/req_b after the grant are ignored.
- Reset asserted in RUN or RESP: the in-flight product is discarded, no resp_valid pulse, state returns to IDLE.
- resp_ready high while resp_valid is low has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH and MUL_LATENCY defaults;
  - the state enum (IDLE, RUN, RESP);
  - an id-width function (clog2).
- Sub-module rr_arbiter: purely combinational. Inputs are the request vector and rr_ptr; outputs are the one-hot grant and its index.
- FSM, counter and output registers stay in mul_share_ctrl. booth_multiplier is instantiated by the parent, not inside this block.

Test Plan:
- Reset then single request: req 0 issues A=8, B=9 at T. mul_a=8, mul_b=9 from T+1. resp_valid rises at T+9 with product 72, id 0. Check with resp_ready=1 and with resp_ready held low 3 cycles (outputs stable throughout).
- Signed operands: req 2 issues A=-3 (8'hFD), B=5 -> resp_product=16'hFFF1, id 2. Also A=-128, B=-128 -> 16'h4000.
- Round-robin, all four requesters asserting continuously from reset: grant order 0,1,2,3,0. Each grant is at least MUL_LATENCY+2 cycles after the previous one, and req_ready is never high outside IDLE.
- Wrap and skip: rr_ptr=2 with only req 1 and req 3 valid -> grant 3, then grant 1.
- Reset at RUN cycle 4: no resp_valid appears, state is IDLE the next cycle, and the next grant goes to req 0.
- Operand stability: change req_a[0] during RUN -> mul_a and resp_product reflect only the captured value.
